rx_data_deframer: RTL and testbench

- Receive-side counterpart of the TX data framer: turns descrambled 64B/66B blocks into a user AXI4-Stream frame (valid/last/data/keep).
- Sits between the RX lane decoder and the user receive interface.
- Data blocks become full 8-byte beats; Separator / Separator-7 blocks close the frame with a partial beat.
- Idle and other control blocks are dropped.
- The AXI output has no backpressure; at most one beat is produced per cycle.

---
 rtl/rx_data_deframer.sv | 181 ++++++++++++++++++
 tb/tb_rx_data_deframer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_data_deframer.sv
// Receive deframer: turns descrambled 64B/66B blocks into AXI4-Stream beats (valid/last/data/keep).
// Optional frame/error statistics counters are compiled in with `define RX_FRAME_STATS_EN.
module rx_data_deframer #(
  parameter int unsigned AXI_DATA_SIZE = 64,
  parameter int unsigned KEEP_SIZE     = AXI_DATA_SIZE / 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_block_valid,
  input  logic [1:0]               rx_header,
  input  logic [AXI_DATA_SIZE-1:0] rx_block,
  output logic                     axi_valid,
  output logic                     axi_last,
  output logic [AXI_DATA_SIZE-1:0] axi_data,
  output logic [KEEP_SIZE-1:0]     axi_keep,
  output logic                     in_frame,
  output logic                     frame_err,
  output logic                     hdr_err
`ifdef RX_FRAME_STATS_EN
  ,
  output logic [15:0]              frame_cnt,
  output logic [15:0]              err_cnt
`endif
);

  localparam logic [7:0] BlkSep  = 8'h1E;
  localparam logic [7:0] BlkSep7 = 8'hE1;

  typedef enum logic {StIdle, StInFrame} state_e;

  state_e                   state_q, state_d;
  logic [AXI_DATA_SIZE-1:0] hold_data_q, hold_data_d;
  logic [KEEP_SIZE-1:0]     hold_keep_q, hold_keep_d;
  logic                     hold_full_q, hold_full_d;
  logic                     hold_last_q, hold_last_d;

  logic                     valid_d, last_d, frame_err_d, hdr_err_d;
  logic [AXI_DATA_SIZE-1:0] data_d;
  logic [KEEP_SIZE-1:0]     keep_d;

  logic [7:0]               blk_type, sep_len;
  logic [3:0]               n_bytes;
  logic [AXI_DATA_SIZE-1:0] sep_data;
  logic [KEEP_SIZE-1:0]     sep_keep;
  logic                     open_beat;

  assign blk_type  = rx_block[63:56];
  assign sep_len   = rx_block[55:48];
  // A held full beat that is not yet the frame's last beat.
  assign open_beat = hold_full_q && !hold_last_q;
  assign sep_keep  = ~({KEEP_SIZE{1'b1}} >> n_bytes);

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_keep_d = hold_keep_q;
    hold_full_d = hold_full_q;
    hold_last_d = hold_last_q;
    valid_d     = 1'b0;
    last_d      = 1'b0;
    data_d      = '0;
    keep_d      = '0;
    frame_err_d = 1'b0;
    hdr_err_d   = 1'b0;
    n_bytes     = 4'd0;
    sep_data    = '0;

    // Pending last beat leaves unconditionally; hold may be reloaded below in the same edge.
    if (hold_full_q && hold_last_q) begin
      valid_d     = 1'b1;
      last_d      = 1'b1;
      data_d      = hold_data_q;
      keep_d      = hold_keep_q;
      hold_full_d = 1'b0;
      hold_last_d = 1'b0;
    end

    if (rx_block_valid) begin
      case (rx_header)
        2'b01: begin
          if (open_beat) begin
            valid_d = 1'b1;
            data_d  = hold_data_q;
            keep_d  = hold_keep_q;
          end
          hold_data_d = rx_block;
          hold_keep_d = '1;
          hold_full_d = 1'b1;
          hold_last_d = 1'b0;
          state_d     = StInFrame;
        end
        2'b10: begin
          if (blk_type == BlkSep || blk_type == BlkSep7) begin
            state_d = StIdle;
            if (blk_type == BlkSep7) begin
              n_bytes  = 4'd7;
              sep_data = {rx_block[55:0], 8'h00};
            end else begin
              sep_data = {rx_block[47:0], 16'h0000};
              if (sep_len > 8'd6) begin
                n_bytes     = 4'd6;
                frame_err_d = 1'b1;
              end else begin
                n_bytes = sep_len[3:0];
              end
            end
            if (n_bytes == 4'd0) begin
              if (open_beat) begin
                valid_d     = 1'b1;
                last_d      = 1'b1;
                data_d      = hold_data_q;
                keep_d      = hold_keep_q;
                hold_full_d = 1'b0;
              end else begin
                frame_err_d = 1'b1;
              end
            end else begin
              if (open_beat) begin
                valid_d = 1'b1;
                data_d  = hold_data_q;
                keep_d  = hold_keep_q;
              end
              hold_data_d = sep_data;
              hold_keep_d = sep_keep;
              hold_full_d = 1'b1;
              hold_last_d = 1'b1;
            end
          end
        end
        default: hdr_err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hold_data_q <= '0;
      hold_keep_q <= '0;
      hold_full_q <= 1'b0;
      hold_last_q <= 1'b0;
      axi_valid   <= 1'b0;
      axi_last    <= 1'b0;
      axi_data    <= '0;
      axi_keep    <= '0;
      frame_err   <= 1'b0;
      hdr_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_keep_q <= hold_keep_d;
      hold_full_q <= hold_full_d;
      hold_last_q <= hold_last_d;
      axi_valid   <= valid_d;
      axi_last    <= last_d;
      axi_data    <= data_d;
      axi_keep    <= keep_d;
      frame_err   <= frame_err_d;
      hdr_err     <= hdr_err_d;
    end
  end

  assign in_frame = (state_q == StInFrame);

`ifdef RX_FRAME_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (axi_valid && axi_last && frame_cnt != 16'hFFFF) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if ((frame_err || hdr_err) && err_cnt != 16'hFFFF) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rx_data_deframer.sv
// Bench for rx_data_deframer: directed test-plan frames plus random blocks against a timeline model.
// Build with RX_FRAME_STATS_EN defined to also check the statistics counters.
module tb_rx_data_deframer;

  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_block_valid;
  logic [1:0]  rx_header;
  logic [63:0] rx_block;
  logic        axi_valid, axi_last, in_frame, frame_err, hdr_err;
  logic [63:0] axi_data;
  logic [7:0]  axi_keep;
`ifdef RX_FRAME_STATS_EN
  logic [15:0] frame_cnt, err_cnt;
`endif

  always #5 clk = ~clk;

  rx_data_deframer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_block_valid (rx_block_valid),
    .rx_header      (rx_header),
    .rx_block       (rx_block),
    .axi_valid      (axi_valid),
    .axi_last       (axi_last),
    .axi_data       (axi_data),
    .axi_keep       (axi_keep),
    .in_frame       (in_frame),
    .frame_err      (frame_err),
    .hdr_err        (hdr_err)
`ifdef RX_FRAME_STATS_EN
    ,
    .frame_cnt      (frame_cnt),
    .err_cnt        (err_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Expected output timeline, indexed by the cycle in which the output is visible.
  bit          ev [MAXC];
  bit          el [MAXC];
  logic [63:0] ed [MAXC];
  logic [7:0]  ek [MAXC];
  bit          efe[MAXC];
  bit          ehe[MAXC];
  bit          eif[MAXC];

  // A data beat is "open" until the next data or separator block decides whether it is last.
  bit          m_open;
  logic [63:0] m_open_d;
  bit          m_frame;
  int          m_lasts, m_errs;

  int          beats_seen, errs_seen;
  logic [63:0] last_d;
  logic [7:0]  last_k;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [7:0] lead_ones(input int n);
    logic [7:0] k = '0;
    for (int i = 0; i < n; i++) k[7-i] = 1'b1;
    return k;
  endfunction

  task automatic sched(input int t, input logic [63:0] d, input logic [7:0] k, input bit l);
    ev[t] = 1'b1;
    ed[t] = d;
    ek[t] = k;
    el[t] = l;
  endtask

  task automatic clear_model();
    for (int i = 0; i < MAXC; i++) begin
      ev[i] = 0; el[i] = 0; ed[i] = '0; ek[i] = '0; efe[i] = 0; ehe[i] = 0; eif[i] = 0;
    end
    m_open  = 0;
    m_frame = 0;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_valid", 64'(axi_valid), 64'd0);
    check_eq("rst_last", 64'(axi_last), 64'd0);
    check_eq("rst_data", axi_data, 64'd0);
    check_eq("rst_keep", 64'(axi_keep), 64'd0);
    check_eq("rst_in_frame", 64'(in_frame), 64'd0);
    check_eq("rst_frame_err", 64'(frame_err), 64'd0);
    check_eq("rst_hdr_err", 64'(hdr_err), 64'd0);
`ifdef RX_FRAME_STATS_EN
    check_eq("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check_eq("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif
  endtask

  task automatic step(input logic v, input logic [1:0] h, input logic [63:0] b);
    int n;
    logic [63:0] sd;
    @(negedge clk);
    if (cyc >= MAXC - 3) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC - 3);
      $fatal(1, "cycle budget exceeded");
    end
    check_eq("valid", 64'(axi_valid), 64'(ev[cyc]));
    check_eq("last", 64'(axi_last), 64'(el[cyc]));
    if (ev[cyc]) begin
      check_eq("data", axi_data, ed[cyc]);
      check_eq("keep", 64'(axi_keep), 64'(ek[cyc]));
    end
    check_eq("in_frame", 64'(in_frame), 64'(eif[cyc]));
    check_eq("frame_err", 64'(frame_err), 64'(efe[cyc]));
    check_eq("hdr_err", 64'(hdr_err), 64'(ehe[cyc]));
    if (axi_valid) beats_seen++;
    if (axi_valid && axi_last) begin
      last_d = axi_data;
      last_k = axi_keep;
    end
    if (frame_err) errs_seen++;
    if (hdr_err) errs_seen++;
    if (ev[cyc] && el[cyc]) m_lasts++;
    if (efe[cyc]) m_errs++;
    if (ehe[cyc]) m_errs++;

    if (v) begin
      if (h == 2'b01) begin
        if (m_open) sched(cyc + 1, m_open_d, 8'hFF, 1'b0);
        m_open   = 1;
        m_open_d = b;
        m_frame  = 1;
      end else if (h == 2'b10) begin
        if (b[63:56] == 8'h1E || b[63:56] == 8'hE1) begin
          if (b[63:56] == 8'hE1) begin
            n  = 7;
            sd = {b[55:0], 8'h00};
          end else begin
            n  = int'(b[55:48]);
            sd = {b[47:0], 16'h0000};
            if (n > 6) begin
              n = 6;
              efe[cyc + 1] = 1;
            end
          end
          if (n == 0) begin
            if (m_open) sched(cyc + 1, m_open_d, 8'hFF, 1'b1);
            else efe[cyc + 1] = 1;
          end else begin
            if (m_open) sched(cyc + 1, m_open_d, 8'hFF, 1'b0);
            sched(cyc + 2, sd, lead_ones(n), 1'b1);
          end
          m_open  = 0;
          m_frame = 0;
        end
      end else begin
        ehe[cyc + 1] = 1;
      end
    end
    eif[cyc + 1] = m_frame;

    rx_block_valid = v;
    rx_header      = h;
    rx_block       = b;
    cyc++;
  endtask

  task automatic send_data(input logic [63:0] b);
    step(1'b1, 2'b01, b);
  endtask

  task automatic send_ctl(input logic [63:0] b);
    step(1'b1, 2'b10, b);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 64'd0);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    rx_block_valid = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    m_lasts = 0;
    m_errs  = 0;
  endtask

  localparam logic [63:0] IdleBlk = 64'h7800_0000_0000_0000;

  initial begin
    logic [63:0] b;
    int r;
    rst_n = 1'b0;
    rx_block_valid = 1'b0;
    rx_header = 2'b00;
    rx_block = '0;
    m_lasts = 0;
    m_errs = 0;
    beats_seen = 0;
    errs_seen = 0;
    last_d = '0;
    last_k = '0;
    clear_model();
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-beat frame
    send_data(64'hDEADB00DDEADB00D);
    send_ctl(64'h1E00_0000_0000_0000);
    idle_cycles(3);
    check_eq("t1_data", last_d, 64'hDEADB00DDEADB00D);
    check_eq("t1_keep", 64'(last_k), 64'hFF);

    // Seven data beats with idles interleaved, then Separator N=3
    beats_seen = 0;
    for (int i = 0; i < 7; i++) begin
      send_data({$urandom, $urandom});
      if (i == 1 || i == 3 || i == 5) send_ctl(IdleBlk);
    end
    send_ctl(64'h1E03_AABB_CC00_0000);
    idle_cycles(3);
    check_eq("t2_beats", 64'(beats_seen), 64'd8);
    check_eq("t2_data", last_d, 64'hAABBCC0000000000);
    check_eq("t2_keep", 64'(last_k), 64'hE0);

    // Separator-7 alone
    send_ctl(64'hE111_2233_4455_6677);
    idle_cycles(3);
    check_eq("t3_data", last_d, 64'h1122334455667700);
    check_eq("t3_keep", 64'(last_k), 64'hFE);

    // Back-to-back: Separator N=2 followed at once by the next frame
    send_ctl(64'h1E02_1234_0000_0000);
    send_data(64'h0102030405060708);
    idle_cycles(1);
    check_eq("t4_keep_c0", 64'(last_k), 64'hC0);
    check_eq("t4_data_c0", last_d, 64'h1234000000000000);
    send_ctl(64'h1E00_0000_0000_0000);
    idle_cycles(2);
    check_eq("t4_next_data", last_d, 64'h0102030405060708);

    // Errors
    errs_seen = 0;
    step(1'b1, 2'b11, 64'h0123456789ABCDEF);
    send_ctl(64'h1E00_0000_0000_0000);
    send_ctl(64'h1E09_1122_3344_5566);
    idle_cycles(3);
    check_eq("t5_errs", 64'(errs_seen), 64'd3);
    check_eq("t5_keep", 64'(last_k), 64'hFC);
`ifdef RX_FRAME_STATS_EN
    check_eq("t5_err_cnt", 64'(err_cnt), 64'd3);
`endif

    // Reset mid-frame, then a fresh frame
    send_data(64'h1111111111111111);
    send_data(64'h2222222222222222);
    do_reset();
    send_data(64'hCAFEF00D12345678);
    send_ctl(64'h1E00_0000_0000_0000);
    idle_cycles(3);
    check_eq("t6_data", last_d, 64'hCAFEF00D12345678);

    // Random blocks
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      b = {$urandom, $urandom};
      if (r < 15) begin
        step(1'b0, 2'(2'b00), b);
      end else if (r < 50) begin
        send_data(b);
      end else if (r < 62) begin
        b[63:56] = 8'h1E;
        b[55:48] = 8'($urandom_range(0, 10));
        send_ctl(b);
      end else if (r < 70) begin
        b[63:56] = 8'hE1;
        send_ctl(b);
      end else if (r < 82) begin
        b[63:56] = 8'h78;
        send_ctl(b);
      end else if (r < 88) begin
        b[63:56] = 8'h4B;
        send_ctl(b);
      end else begin
        step(1'b1, ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11, b);
      end
    end
    idle_cycles(4);
`ifdef RX_FRAME_STATS_EN
    check_eq("frame_cnt", 64'(frame_cnt), 64'(m_lasts));
    check_eq("err_cnt", 64'(err_cnt), 64'(m_errs));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
